spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Round-robin scheduler that shares one SPI master transmitter (sysclk domain, Mode 0, active-low chip select) between NUM_REQ on-chip requesters.
- Accepts {cmd, addr, payload} requests and assembles the master input frame.
- Launches the frame with a single-cycle transmit enable, then tracks chip select to detect transaction start and end.
- Captures the slave response and returns it, tagged with the requester ID, with start/finish timeouts and a minimum chip-select-high gap between transactions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CMD_W, 8, command field width.
- ADDR_W, 8, address field width.
- DATA_W, 16, payload field width.
- FRAME_W, CMD_W+ADDR_W+DATA_W, master frame width; must be <= 32.
- RESP_W, 7, response width (brightness field).
- START_TO, 64, sysclk cycles allowed from launch to chip-select assertion.
- XFER_TO, 1024, sysclk cycles allowed from chip-select assertion to deassertion.
- GAP_CYCLES, 4, minimum sysclk cycles chip select stays high between transactions (>= 1).

Ports:
- sysclk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until granted.
- req_cmd  in  NUM_REQ*CMD_W  packed commands; requester i occupies slice [i*CMD_W +: CMD_W].
- req_addr  in  NUM_REQ*ADDR_W  packed addresses.
- req_data  in  NUM_REQ*DATA_W  packed payloads.
- gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  $clog2(NUM_REQ)  requester index for the response.
- rsp_data  out  RESP_W  captured slave response.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.
- m_tx_enb  out  1  transmit enable to the master.
- m_frame  out  FRAME_W  frame to the master; cmd in MSBs, then addr, then payload.
- m_cs_n  in  1  master chip select (0 = asserted).
- m_rx_frame  in  RESP_W  master response output.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer last=NUM_REQ-1 (requester 0 has first priority). Reset mid-transaction aborts immediately; no response is emitted for the aborted request.
- FSM states: IDLE, LAUNCH, WAIT_CS_LOW, WAIT_CS_HIGH, RESP, GAP.
- IDLE: when |req && m_cs_n==1, select the first requester with req set, searching from last+1 upward and wrapping modulo NUM_REQ. At that edge: register the winner's index, latch m_frame={cmd,addr,data}, set last=winner, go to LAUNCH. If m_cs_n==0 (e.g. master still active after our reset), stay in IDLE.
- LAUNCH (1 cycle): gnt[winner]=1 and m_tx_enb=1 for exactly this cycle; go to WAIT_CS_LOW and clear the timer. Request-to-gnt latency is 1 cycle after req is sampled in IDLE.
- m_frame is held stable from LAUNCH until the transaction leaves WAIT_CS_HIGH. Requesters may change fields or drop req after gnt.
- WAIT_CS_LOW: on m_cs_n==0 go to WAIT_CS_HIGH and clear the timer. If the timer reaches START_TO-1, go to RESP with error.
- WAIT_CS_HIGH: on m_cs_n==1 sample m_rx_frame into rsp_data at that edge and go to RESP with no error. If the timer reaches XFER_TO-1, go to RESP with error.
- RESP (1 cycle): rsp_valid=1 with rsp_id set. rsp_err=1 and rsp_data=0 on timeout. Go to GAP.
- rsp_id, rsp_data and rsp_err hold their values until the next RESP.
- GAP: count GAP_CYCLES cycles with m_cs_n==1, then go to IDLE. The count restarts if m_cs_n goes low (stale master activity after a timeout).
- Timer: saturating counter sized $clog2(max(START_TO, XFER_TO, GAP_CYCLES))+1.
- Only one transaction is in flight at a time. A request arriving while busy waits; no request is lost or reordered within a requester.
- Simultaneous requests: exactly one grant per transaction, in round-robin order. A requester re-asserting immediately after its own grant is served only after all other pending requesters.
- Single requester: back-to-back service; cs-high spacing >= GAP_CYCLES+2 cycles (GAP plus IDLE and LAUNCH).

Test Plan:
- Single request: reset, req=4'b0001 with cmd=8'hA5, addr=8'h3C, data=16'h1234 → gnt=0001 and m_tx_enb high in the same cycle, m_frame=32'hA53C1234; master mock returns 7'h55 → rsp_valid, rsp_id=0, rsp_data=7'h55, rsp_err=0.
- Contention: req=4'b1111 held continuously → grant order 0,1,2,3,0. Exactly one gnt bit per transaction; m_tx_enb never reasserts while m_cs_n==0.
- Fairness: req[2] held continuously, req[0] asserted mid-transaction → next grant goes to 0, then 2.
- Start timeout: m_cs_n tied 1 → rsp_valid with rsp_err=1 and rsp_data=0 exactly START_TO+1 cycles after LAUNCH; busy falls after GAP_CYCLES more cycles.
- Transfer timeout: force m_cs_n low permanently → rsp_err=1 after XFER_TO cycles. Arbiter then stays in GAP while m_cs_n==0 and issues no new m_tx_enb.
- Reset mid-transaction: assert rst during WAIT_CS_HIGH → all outputs 0 the next cycle, no rsp_valid. The next grant after reset is withheld until m_cs_n==1 and goes to requester 0.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler sharing one SPI master between NUM_REQ requesters.
// It launches the winner's frame, tracks chip select, and returns the tagged response.
module spi_txn_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int CMD_W      = 8,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int FRAME_W    = CMD_W + ADDR_W + DATA_W,
  parameter int RESP_W     = 7,
  parameter int START_TO   = 64,
  parameter int XFER_TO    = 1024,
  parameter int GAP_CYCLES = 4
) (
  input  logic                         sysclk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CMD_W-1:0]     req_cmd,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [RESP_W-1:0]            rsp_data,
  output logic                         rsp_err,
  output logic                         busy,
  output logic                         m_tx_enb,
  output logic [FRAME_W-1:0]           m_frame,
  input  logic                         m_cs_n,
  input  logic [RESP_W-1:0]            m_rx_frame
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CW      = ID_W + 1;
  localparam int TMR_MAX = (START_TO > XFER_TO)
                           ? ((START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES)
                           : ((XFER_TO > GAP_CYCLES) ? XFER_TO : GAP_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_CS_LOW,
    S_WAIT_CS_HIGH,
    S_RESP,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ID_W-1:0]     r_winner;
  logic [ID_W-1:0]     r_last;
  logic [TMR_W-1:0]    r_timer;
  logic [TMR_W-1:0]    w_timer_next;
  logic [TMR_W-1:0]    w_timer_inc;
  logic [FRAME_W-1:0]  r_frame;
  logic [ID_W-1:0]     r_rsp_id;
  logic [RESP_W-1:0]   r_rsp_data;
  logic                r_rsp_err;

  logic                w_found;
  logic [ID_W-1:0]     w_winner;
  logic [CW-1:0]       w_cand;
  logic [FRAME_W-1:0]  w_frame;
  logic                w_take;
  logic                w_load_rsp;
  logic                w_rsp_err_next;
  logic [RESP_W-1:0]   w_rsp_data_next;

  assign w_timer_inc = (r_timer == {TMR_W{1'b1}}) ? r_timer : r_timer + TMR_W'(1);

  assign busy     = (r_state != S_IDLE);
  assign m_frame  = r_frame;
  assign rsp_id   = r_rsp_id;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

  // Search upward from the requester after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    w_frame  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_last} + CW'(k);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end
      if (!w_found && req[w_cand[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[ID_W-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_frame = {req_cmd[i*CMD_W +: CMD_W], req_addr[i*ADDR_W +: ADDR_W],
                   req_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = r_timer;
    w_take          = 1'b0;
    w_load_rsp      = 1'b0;
    w_rsp_err_next  = 1'b0;
    w_rsp_data_next = '0;
    gnt             = '0;
    m_tx_enb        = 1'b0;
    rsp_valid       = 1'b0;
    case (r_state)
      // A master still busy from before our reset blocks new launches.
      S_IDLE: begin
        if (w_found && m_cs_n) begin
          w_take       = 1'b1;
          w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        gnt[r_winner] = 1'b1;
        m_tx_enb      = 1'b1;
        w_timer_next  = '0;
        w_state_next  = S_WAIT_CS_LOW;
      end
      S_WAIT_CS_LOW: begin
        if (!m_cs_n) begin
          w_timer_next = '0;
          w_state_next = S_WAIT_CS_HIGH;
        end else if (r_timer == TMR_W'(START_TO - 1)) begin
          w_load_rsp     = 1'b1;
          w_rsp_err_next = 1'b1;
          w_state_next   = S_RESP;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
      S_WAIT_CS_HIGH: begin
        if (m_cs_n) begin
          w_load_rsp      = 1'b1;
          w_rsp_data_next = m_rx_frame;
          w_state_next    = S_RESP;
        end else if (r_timer == TMR_W'(XFER_TO - 1)) begin
          w_load_rsp     = 1'b1;
          w_rsp_err_next = 1'b1;
          w_state_next   = S_RESP;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
      S_RESP: begin
        rsp_valid    = 1'b1;
        w_timer_next = '0;
        w_state_next = S_GAP;
      end
      // Any low chip select here is stale activity, so the quiet period starts over.
      S_GAP: begin
        if (!m_cs_n) begin
          w_timer_next = '0;
        end else if (r_timer == TMR_W'(GAP_CYCLES - 1)) begin
          w_state_next = S_IDLE;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_timer    <= '0;
      r_winner   <= '0;
      r_last     <= ID_W'(NUM_REQ - 1);
      r_frame    <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_timer <= w_timer_next;
      if (w_take) begin
        r_winner <= w_winner;
        r_last   <= w_winner;
        r_frame  <= w_frame;
      end
      if (w_load_rsp) begin
        r_rsp_id   <= r_winner;
        r_rsp_data <= w_rsp_data_next;
        r_rsp_err  <= w_rsp_err_next;
      end
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed testbench for spi_txn_arbiter with a small SPI master mock.
// The mock either runs a short transaction per launch or pins chip select high/low.
module tb_spi_txn_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int CMD_W      = 8;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int FRAME_W    = 32;
  localparam int RESP_W     = 7;
  localparam int START_TO   = 64;
  localparam int XFER_TO    = 1024;
  localparam int GAP_CYCLES = 4;

  localparam int MOCK_AUTO = 0;
  localparam int MOCK_HIGH = 1;
  localparam int MOCK_LOW  = 2;

  logic                       sysclk;
  logic                       rst;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*CMD_W-1:0]   req_cmd;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         gnt;
  logic                       rsp_valid;
  logic [1:0]                 rsp_id;
  logic [RESP_W-1:0]          rsp_data;
  logic                       rsp_err;
  logic                       busy;
  logic                       m_tx_enb;
  logic [FRAME_W-1:0]         m_frame;
  logic                       m_cs_n;
  logic [RESP_W-1:0]          m_rx_frame;

  int          total = 0;
  int          passed = 0;
  int          mock_mode;
  logic [6:0]  mock_rsp;
  int          bad_launch = 0;
  int          mock_phase = 0;
  int          mock_cnt = 0;

  spi_txn_arbiter #(
    .NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FRAME_W(FRAME_W), .RESP_W(RESP_W), .START_TO(START_TO), .XFER_TO(XFER_TO),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .sysclk(sysclk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .m_tx_enb(m_tx_enb),
    .m_frame(m_frame), .m_cs_n(m_cs_n), .m_rx_frame(m_rx_frame)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Master mock: acts on falling edges; in AUTO mode cs goes low 2 cycles after a launch for 8 cycles.
  initial begin
    m_cs_n     = 1'b1;
    m_rx_frame = '0;
    forever begin
      @(negedge sysclk);
      if (mock_mode == MOCK_HIGH) begin
        m_cs_n     = 1'b1;
        mock_phase = 0;
      end else if (mock_mode == MOCK_LOW) begin
        m_cs_n     = 1'b0;
        mock_phase = 0;
      end else begin
        case (mock_phase)
          0: if (m_tx_enb) begin
               if (!m_cs_n) bad_launch++;
               mock_phase = 1;
               mock_cnt   = 0;
             end
          1: begin
               mock_cnt++;
               if (mock_cnt == 2) begin
                 m_cs_n     = 1'b0;
                 mock_phase = 2;
                 mock_cnt   = 0;
               end
             end
          default: begin
               mock_cnt++;
               if (mock_cnt == 8) begin
                 m_rx_frame = mock_rsp;
                 m_cs_n     = 1'b1;
                 mock_phase = 0;
               end
             end
        endcase
      end
    end
  end

  task automatic tick;
    @(negedge sysclk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic set_fields(input int i, input logic [7:0] c, input logic [7:0] a,
                            input logic [15:0] d);
    req_cmd[i*CMD_W +: CMD_W]    = c;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic wait_gnt(input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick;
      if (|gnt) seen = 1'b1;
    end
  endtask

  task automatic wait_rsp(input int budget, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (cycles < budget && !seen) begin
      tick;
      cycles++;
      if (rsp_valid) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (cycles < budget && !seen) begin
      tick;
      cycles++;
      if (!busy) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    do_reset;
    tick;
    total++; if (gnt !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); else passed++;
    total++; if (m_tx_enb !== 1'b0) $display("[TB] FAIL reset_tx_enb: got %b expected 0", m_tx_enb); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passed++;
    total++; if (m_frame !== 32'h0) $display("[TB] FAIL reset_frame: got %h expected 0", m_frame); else passed++;
    total++; if ({rsp_id, rsp_data, rsp_err} !== 10'h0) $display("[TB] FAIL reset_rsp_regs: got id=%0d data=%h err=%b expected zeros", rsp_id, rsp_data, rsp_err); else passed++;
  endtask

  task automatic test_single;
    int cyc;
    bit seen;
    mock_mode = MOCK_AUTO;
    mock_rsp  = 7'h55;
    set_fields(0, 8'hA5, 8'h3C, 16'h1234);
    req = 4'b0001;
    tick;
    total++; if (gnt !== 4'b0001) $display("[TB] FAIL single_gnt: got %b expected 0001", gnt); else passed++;
    total++; if (m_tx_enb !== 1'b1) $display("[TB] FAIL single_tx_enb: got %b expected 1", m_tx_enb); else passed++;
    total++; if (m_frame !== 32'hA53C1234) $display("[TB] FAIL single_frame: got %h expected a53c1234", m_frame); else passed++;
    req = 4'b0000;
    wait_rsp(100, cyc, seen);
    total++; if (!seen || rsp_id !== 2'd0 || rsp_data !== 7'h55 || rsp_err !== 1'b0)
      $display("[TB] FAIL single_rsp: got valid=%b id=%0d data=%h err=%b expected 1/0/55/0", seen, rsp_id, rsp_data, rsp_err);
    else passed++;
    wait_idle(20, cyc, seen);
  endtask

  task automatic test_contention;
    int cyc;
    bit seen;
    logic [3:0] exp_gnt;
    logic [7:0] exp_cmd;
    do_reset;
    mock_rsp = 7'h2A;
    for (int i = 0; i < NUM_REQ; i++) set_fields(i, 8'h10 + 8'(i), 8'h20 + 8'(i), 16'h3000 + 16'(i));
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_gnt = 4'b0001 << (t % 4);
      exp_cmd = 8'h10 + 8'(t % 4);
      wait_gnt(200, seen);
      if (t == 4) req = 4'b0000;
      total++; if (gnt !== exp_gnt) $display("[TB] FAIL contention_gnt%0d: got %b expected %b", t, gnt, exp_gnt); else passed++;
      total++; if (m_frame[31:24] !== exp_cmd) $display("[TB] FAIL contention_cmd%0d: got %h expected %h", t, m_frame[31:24], exp_cmd); else passed++;
    end
    wait_idle(100, cyc, seen);
    total++; if (bad_launch !== 0) $display("[TB] FAIL contention_launch_cs_low: got %0d expected 0", bad_launch); else passed++;
  endtask

  task automatic test_fairness;
    int cyc;
    bit seen;
    mock_rsp = 7'h19;
    req = 4'b0100;
    wait_gnt(50, seen);
    total++; if (gnt !== 4'b0100) $display("[TB] FAIL fair_first: got %b expected 0100", gnt); else passed++;
    repeat (3) tick;
    req = 4'b0101;
    wait_gnt(100, seen);
    req = 4'b0100;
    total++; if (gnt !== 4'b0001) $display("[TB] FAIL fair_second: got %b expected 0001", gnt); else passed++;
    wait_gnt(100, seen);
    req = 4'b0000;
    total++; if (gnt !== 4'b0100) $display("[TB] FAIL fair_third: got %b expected 0100", gnt); else passed++;
    wait_rsp(100, cyc, seen);
    total++; if (!seen || rsp_id !== 2'd2 || rsp_data !== 7'h19)
      $display("[TB] FAIL fair_rsp: got valid=%b id=%0d data=%h expected 1/2/19", seen, rsp_id, rsp_data);
    else passed++;
    wait_idle(50, cyc, seen);
  endtask

  task automatic test_start_timeout;
    int cyc;
    bit seen;
    mock_mode = MOCK_HIGH;
    tick;
    req = 4'b0010;
    wait_gnt(50, seen);
    req = 4'b0000;
    total++; if (gnt !== 4'b0010) $display("[TB] FAIL start_to_gnt: got %b expected 0010", gnt); else passed++;
    wait_rsp(200, cyc, seen);
    total++; if (!seen || cyc != START_TO + 1) $display("[TB] FAIL start_to_latency: got %0d cycles (valid=%b) expected %0d", cyc, seen, START_TO + 1); else passed++;
    total++; if (rsp_err !== 1'b1 || rsp_data !== 7'h00 || rsp_id !== 2'd1)
      $display("[TB] FAIL start_to_rsp: got err=%b data=%h id=%0d expected 1/00/1", rsp_err, rsp_data, rsp_id);
    else passed++;
    wait_idle(50, cyc, seen);
    total++; if (!seen || cyc != GAP_CYCLES + 1) $display("[TB] FAIL start_to_gap: got %0d cycles expected %0d", cyc, GAP_CYCLES + 1); else passed++;
  endtask

  task automatic test_xfer_timeout;
    int cyc;
    int launches;
    bit seen;
    req = 4'b0100;
    wait_gnt(50, seen);
    req = 4'b0000;
    mock_mode = MOCK_LOW;
    total++; if (gnt !== 4'b0100) $display("[TB] FAIL xfer_to_gnt: got %b expected 0100", gnt); else passed++;
    tick;
    wait_rsp(1200, cyc, seen);
    total++; if (!seen || cyc != XFER_TO + 1) $display("[TB] FAIL xfer_to_latency: got %0d cycles (valid=%b) expected %0d", cyc, seen, XFER_TO + 1); else passed++;
    total++; if (rsp_err !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 7'h00)
      $display("[TB] FAIL xfer_to_rsp: got err=%b id=%0d data=%h expected 1/2/00", rsp_err, rsp_id, rsp_data);
    else passed++;
    req = 4'b0001;
    launches = 0;
    for (int n = 0; n < 20; n++) begin
      tick;
      if (m_tx_enb || (|gnt)) launches++;
    end
    total++; if (launches != 0 || busy !== 1'b1) $display("[TB] FAIL xfer_to_stale_gap: got launches=%0d busy=%b expected 0/1", launches, busy); else passed++;
    req = 4'b0000;
    mock_mode = MOCK_HIGH;
    wait_idle(20, cyc, seen);
    total++; if (!seen || cyc != GAP_CYCLES + 1) $display("[TB] FAIL xfer_to_release: got %0d cycles expected %0d", cyc, GAP_CYCLES + 1); else passed++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    int spurious;
    bit seen;
    set_fields(3, 8'hC3, 8'h5A, 16'hBEEF);
    req = 4'b1000;
    wait_gnt(50, seen);
    mock_mode = MOCK_LOW;
    total++; if (gnt !== 4'b1000) $display("[TB] FAIL rst_mid_gnt: got %b expected 1000", gnt); else passed++;
    set_fields(3, 8'h00, 8'h00, 16'h0000);
    repeat (5) tick;
    total++; if (busy !== 1'b1 || m_frame !== 32'hC35ABEEF) $display("[TB] FAIL rst_mid_hold: got busy=%b frame=%h expected 1/c35abeef", busy, m_frame); else passed++;
    rst = 1'b1;
    tick;
    total++; if (busy !== 1'b0 || gnt !== 4'b0000 || m_tx_enb !== 1'b0 || rsp_valid !== 1'b0)
      $display("[TB] FAIL rst_mid_ctrl: got busy=%b gnt=%b tx=%b valid=%b expected zeros", busy, gnt, m_tx_enb, rsp_valid);
    else passed++;
    total++; if (m_frame !== 32'h0 || rsp_id !== 2'd0 || rsp_err !== 1'b0 || rsp_data !== 7'h00)
      $display("[TB] FAIL rst_mid_regs: got frame=%h id=%0d err=%b data=%h expected zeros", m_frame, rsp_id, rsp_err, rsp_data);
    else passed++;
    rst = 1'b0;
    req = 4'b1001;
    spurious = 0;
    for (int n = 0; n < 10; n++) begin
      tick;
      if ((|gnt) || rsp_valid || busy) spurious++;
    end
    total++; if (spurious != 0) $display("[TB] FAIL rst_mid_withheld: got %0d active cycles expected 0", spurious); else passed++;
    mock_mode = MOCK_HIGH;
    wait_gnt(10, seen);
    req = 4'b0000;
    total++; if (gnt !== 4'b0001) $display("[TB] FAIL rst_mid_regrant: got %b expected 0001", gnt); else passed++;
    wait_idle(200, cyc, seen);
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_cmd   = '0;
    req_addr  = '0;
    req_data  = '0;
    mock_mode = MOCK_AUTO;
    mock_rsp  = '0;
    test_reset;
    test_single;
    test_contention;
    test_fairness;
    test_start_timeout;
    test_xfer_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
